// File: rtl/wb_buffer.sv
// Write-back buffer: small FIFO of dirty evicted blocks between the cache and main memory.
// Forwards buffered blocks to cache reads and drains the FIFO to memory when idle.
module wb_buffer #(
   parameter int PA_WIDTH  = 32,
   parameter int BLK_WIDTH = 512,
   parameter int DEPTH     = 4,
   parameter int MEM_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PA_WIDTH-1:0]  cache_addr,
   input  logic                 cache_wr_en,
   input  logic [BLK_WIDTH-1:0] cache_wr_blk,
   input  logic                 cache_rd_en,
   output logic [BLK_WIDTH-1:0] cache_rd_blk,
   output logic                 cache_rdy,
   output logic [PA_WIDTH-1:0]  mem_addr,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [BLK_WIDTH-1:0] mem_wr_blk,
   input  logic [BLK_WIDTH-1:0] mem_rd_blk,
   output logic                 wb_empty,
   output logic                 wb_full
);

   localparam int OFF_W = 6;
   localparam int TAG_W = PA_WIDTH - OFF_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [2:0] {IDLE, WR_ACC, RD_ISSUE, RD_WAIT, DRAIN, RESP} state_t;

   state_t state_reg, state_next;

   logic [TAG_W-1:0]     tag_mem  [DEPTH];
   logic [BLK_WIDTH-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]     valid_reg;
   logic [PTR_W-1:0]     head_reg, tail_reg;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic [LAT_W-1:0]     lat_cnt_reg;
   logic                 stall_reg;

   logic [BLK_WIDTH-1:0] cache_rd_blk_reg;
   logic                 cache_rdy_reg;
   logic [PA_WIDTH-1:0]  mem_addr_reg;
   logic                 mem_rd_en_reg;
   logic                 mem_wr_en_reg;
   logic [BLK_WIDTH-1:0] mem_wr_blk_reg;
   logic                 wb_empty_reg;
   logic                 wb_full_reg;

   logic [TAG_W-1:0]     cache_tag;
   logic [DEPTH-1:0]     hit_vec;
   logic                 hit;
   logic [PTR_W-1:0]     hit_idx;
   logic                 buf_full, buf_empty;

   logic do_push, do_pop, do_coalesce, do_fwd, do_rd_issue, do_capture, start_drain, set_stall;

   logic unused_offset;
   assign unused_offset = ^cache_addr[OFF_W-1:0];

   assign cache_tag = cache_addr[PA_WIDTH-1:OFF_W];
   assign buf_full  = (count_reg == CNT_W'(DEPTH));
   assign buf_empty = (count_reg == '0);

   // Block-address compare against every live entry; coalescing keeps tags unique.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign hit_vec[gi] = valid_reg[gi] && (tag_mem[gi] == cache_tag);
      end
   endgenerate

   assign hit = |hit_vec;

   always_comb begin
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = PTR_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      do_coalesce = 1'b0;
      do_fwd      = 1'b0;
      do_rd_issue = 1'b0;
      do_capture  = 1'b0;
      start_drain = 1'b0;
      set_stall   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cache_wr_en) begin
               if (hit) begin
                  do_coalesce = 1'b1;
                  state_next  = RESP;
               end else if (!buf_full) begin
                  do_push    = 1'b1;
                  state_next = RESP;
               end else begin
                  start_drain = 1'b1;
                  set_stall   = 1'b1;
                  state_next  = DRAIN;
               end
            end else if (cache_rd_en) begin
               if (hit) begin
                  do_fwd     = 1'b1;
                  state_next = RESP;
               end else begin
                  do_rd_issue = 1'b1;
                  state_next  = RD_ISSUE;
               end
            end else if (!buf_empty) begin
               start_drain = 1'b1;
               state_next  = DRAIN;
            end
         end
         RD_ISSUE: state_next = RD_WAIT;
         RD_WAIT: begin
            if (lat_cnt_reg == LAT_W'(MEM_LAT)) begin
               do_capture = 1'b1;
               state_next = RESP;
            end
         end
         DRAIN: begin
            do_pop     = 1'b1;
            state_next = stall_reg ? WR_ACC : IDLE;
         end
         WR_ACC: begin
            do_push    = 1'b1;
            state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (do_push)     count_next = count_reg + CNT_W'(1);
      else if (do_pop) count_next = count_reg - CNT_W'(1);
   end

   // Entry storage carries no reset; the valid bits alone define occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         tag_mem[tail_reg]  <= cache_tag;
         data_mem[tail_reg] <= cache_wr_blk;
      end else if (do_coalesce) begin
         data_mem[hit_idx] <= cache_wr_blk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg        <= '0;
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         lat_cnt_reg      <= '0;
         stall_reg        <= 1'b0;
         cache_rd_blk_reg <= '0;
         cache_rdy_reg    <= 1'b0;
         mem_addr_reg     <= '0;
         mem_rd_en_reg    <= 1'b0;
         mem_wr_en_reg    <= 1'b0;
         mem_wr_blk_reg   <= '0;
         wb_empty_reg     <= 1'b1;
         wb_full_reg      <= 1'b0;
      end else begin
         cache_rdy_reg <= (state_next == RESP);
         mem_rd_en_reg <= do_rd_issue;
         mem_wr_en_reg <= start_drain;
         count_reg     <= count_next;
         wb_empty_reg  <= (count_next == '0);
         wb_full_reg   <= (count_next == CNT_W'(DEPTH));

         if (do_rd_issue) mem_addr_reg <= {cache_tag, {OFF_W{1'b0}}};
         // Drain data is captured on entry to DRAIN so the strobe cycle presents a stable head.
         if (start_drain) begin
            mem_addr_reg   <= {tag_mem[head_reg], {OFF_W{1'b0}}};
            mem_wr_blk_reg <= data_mem[head_reg];
         end

         if (do_fwd)          cache_rd_blk_reg <= data_mem[hit_idx];
         else if (do_capture) cache_rd_blk_reg <= mem_rd_blk;

         if (state_reg == RD_ISSUE)     lat_cnt_reg <= LAT_W'(1);
         else if (state_reg == RD_WAIT) lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);

         if (set_stall)   stall_reg <= 1'b1;
         else if (do_pop) stall_reg <= 1'b0;

         if (do_push) begin
            valid_reg[tail_reg] <= 1'b1;
            tail_reg            <= tail_reg + PTR_W'(1);
         end
         if (do_pop) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + PTR_W'(1);
         end
      end
   end

   assign cache_rd_blk = cache_rd_blk_reg;
   assign cache_rdy    = cache_rdy_reg;
   assign mem_addr     = mem_addr_reg;
   assign mem_rd_en    = mem_rd_en_reg;
   assign mem_wr_en    = mem_wr_en_reg;
   assign mem_wr_blk   = mem_wr_blk_reg;
   assign wb_empty     = wb_empty_reg;
   assign wb_full      = wb_full_reg;

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: a buffer+memory model feeds a scoreboard of
// expected cache responses, and a memory monitor checks every drain against the model FIFO.
module tb_wb_buffer;

   localparam int PA_WIDTH  = 32;
   localparam int BLK_WIDTH = 512;
   localparam int DEPTH     = 4;
   localparam int MEM_LAT   = 1;
   localparam int TIMEOUT   = 30;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [PA_WIDTH-1:0]  cache_addr;
   logic                 cache_wr_en;
   logic [BLK_WIDTH-1:0] cache_wr_blk;
   logic                 cache_rd_en;
   logic [BLK_WIDTH-1:0] cache_rd_blk;
   logic                 cache_rdy;
   logic [PA_WIDTH-1:0]  mem_addr;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic [BLK_WIDTH-1:0] mem_wr_blk;
   logic [BLK_WIDTH-1:0] mem_rd_blk;
   logic                 wb_empty;
   logic                 wb_full;

   wb_buffer #(.PA_WIDTH(PA_WIDTH), .BLK_WIDTH(BLK_WIDTH), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .cache_addr(cache_addr), .cache_wr_en(cache_wr_en), .cache_wr_blk(cache_wr_blk),
      .cache_rd_en(cache_rd_en), .cache_rd_blk(cache_rd_blk), .cache_rdy(cache_rdy),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk),
      .wb_empty(wb_empty), .wb_full(wb_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                   is_rd;
      logic [PA_WIDTH-1:0]  addr;
      logic [BLK_WIDTH-1:0] data;
   } txn_t;

   txn_t                 txn_q[$];     // expected cache responses, in request order
   txn_t                 model_q[$];   // expected buffer contents, head first
   logic [BLK_WIDTH-1:0] mem_store [logic [PA_WIDTH-1:0]];

   int   checks   = 0;
   int   failures = 0;
   int   wr_cnt   = 0;
   int   rd_cnt   = 0;
   logic [PA_WIDTH-1:0] last_rd_addr = '1;
   bit   after_rdy = 1'b0;

   task automatic check(input string tag, input logic [BLK_WIDTH-1:0] got, input logic [BLK_WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [BLK_WIDTH-1:0] mem_val(input logic [PA_WIDTH-1:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return {16{a ^ 32'h5A5A_1234}};
   endfunction

   function automatic logic [BLK_WIDTH-1:0] exp_read(input logic [PA_WIDTH-1:0] a);
      foreach (model_q[i]) if (model_q[i].addr == a) return model_q[i].data;
      return mem_val(a);
   endfunction

   function automatic logic [BLK_WIDTH-1:0] mk(input logic [31:0] seed);
      return {16{seed}};
   endfunction

   function automatic void model_write(input logic [PA_WIDTH-1:0] a, input logic [BLK_WIDTH-1:0] d);
      txn_t e;
      foreach (model_q[i]) begin
         if (model_q[i].addr == a) begin
            model_q[i].data = d;
            return;
         end
      end
      e.is_rd = 1'b0;
      e.addr  = a;
      e.data  = d;
      model_q.push_back(e);
   endfunction

   // Memory model and drain monitor; read data is valid for exactly one edge MEM_LAT cycles after the strobe.
   initial begin
      int pend_cnt = 0;
      logic [PA_WIDTH-1:0] pend_addr = '0;
      txn_t e;
      mem_rd_blk = '0;
      forever begin
         @(negedge clk);
         mem_rd_blk = {16{32'hDEAD_BEEF}};
         if (rst) pend_cnt = 0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) mem_rd_blk = mem_val(pend_addr);
         end
         if (mem_rd_en || mem_wr_en) check("strobe_excl", {511'b0, mem_rd_en & mem_wr_en}, '0);
         if (mem_rd_en) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
            pend_addr    = mem_addr;
            pend_cnt     = MEM_LAT;
            check("rd_align", {506'b0, mem_addr[5:0]}, '0);
         end
         if (mem_wr_en) begin
            wr_cnt++;
            $display("drain addr=%h", mem_addr);
            if (model_q.size() == 0) begin
               check("drain_extra", {511'b0, mem_wr_en}, '0);
            end else begin
               e = model_q.pop_front();
               check("drain_addr", {480'b0, mem_addr}, {480'b0, e.addr});
               check("drain_data", mem_wr_blk, e.data);
            end
            mem_store[mem_addr] = mem_wr_blk;
         end
      end
   end

   task automatic idle(input int n);
      cache_wr_en = 1'b0;
      cache_rd_en = 1'b0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
      after_rdy = 1'b0;
   endtask

   // Issue one request and wait for cache_rdy. A request issued straight after a
   // response is sampled one edge later, in the IDLE cycle that follows RESP.
   task automatic do_req(input bit wr, input logic [PA_WIDTH-1:0] a, input logic [BLK_WIDTH-1:0] d,
                         input int exp_lat, input string tag);
      txn_t t;
      int n;
      t.is_rd = !wr;
      t.addr  = {a[PA_WIDTH-1:6], 6'b0};
      t.data  = wr ? d : exp_read(t.addr);
      txn_q.push_back(t);
      cache_addr   = a;
      cache_wr_en  = wr;
      cache_rd_en  = !wr;
      cache_wr_blk = wr ? d : '0;
      if (after_rdy) begin
         @(posedge clk);
         @(negedge clk);
      end
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!cache_rdy && n < TIMEOUT);
      check({tag, "_rdy"}, {511'b0, cache_rdy}, {511'b0, 1'b1});
      if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
      t = txn_q.pop_front();
      if (t.is_rd) check({tag, "_data"}, cache_rd_blk, t.data);
      else model_write(t.addr, t.data);
      $display("%s %s addr=%h lat=%0d", tag, wr ? "wr" : "rd", a, n);
      after_rdy = 1'b1;
   endtask

   initial begin
      int wr_base, rd_base;
      rst          = 1'b1;
      cache_addr   = '0;
      cache_wr_en  = 1'b0;
      cache_rd_en  = 1'b0;
      cache_wr_blk = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy",      {511'b0, cache_rdy}, '0);
      check("rst_rd_blk",   cache_rd_blk, '0);
      check("rst_mem_rd",   {511'b0, mem_rd_en}, '0);
      check("rst_mem_wr",   {511'b0, mem_wr_en}, '0);
      check("rst_mem_addr", {480'b0, mem_addr}, '0);
      check("rst_wr_blk",   mem_wr_blk, '0);
      check("rst_empty",    {511'b0, wb_empty}, {511'b0, 1'b1});
      check("rst_full",     {511'b0, wb_full}, '0);
      rst = 1'b0;

      // Read miss on an empty buffer.
      rd_base = rd_cnt;
      do_req(1'b0, 32'h0000_0000, '0, 2 + MEM_LAT, "miss0");
      check("miss0_rdcnt", rd_cnt - rd_base, 1);
      check("miss0_addr", {480'b0, last_rd_addr}, '0);
      idle(3);

      // Write then immediate read of the same block: forwarded, no memory read.
      rd_base = rd_cnt;
      do_req(1'b1, 32'h0000_20d5, mk(32'hAAAA_0001), 1, "wrA");
      do_req(1'b0, 32'h0000_20c0, '0, 1, "fwdA");
      check("fwdA_rdcnt", rd_cnt - rd_base, 0);
      idle(6);
      check("fwdA_empty", {511'b0, wb_empty}, {511'b0, 1'b1});

      // Coalescing: two writes to one block drain once with the newer data.
      wr_base = wr_cnt;
      do_req(1'b1, 32'h0000_2000, mk(32'hAAAA_0002), 1, "coalA");
      do_req(1'b1, 32'h0000_2010, mk(32'hBBBB_0002), 1, "coalB");
      check("coal_nonempty", {511'b0, wb_empty}, '0);
      idle(6);
      check("coal_wrcnt", wr_cnt - wr_base, 1);
      check("coal_empty", {511'b0, wb_empty}, {511'b0, 1'b1});

      // Fill to DEPTH, then a write that has to drain the head first.
      wr_base = wr_cnt;
      do_req(1'b1, 32'h0000_0000, mk(32'hC000_0000), 1, "fill0");
      do_req(1'b1, 32'h0000_0040, mk(32'hC000_0040), 1, "fill1");
      do_req(1'b1, 32'h0000_0080, mk(32'hC000_0080), 1, "fill2");
      do_req(1'b1, 32'h0000_00C0, mk(32'hC000_00C0), 1, "fill3");
      check("fill_full", {511'b0, wb_full}, {511'b0, 1'b1});
      check("fill_wrcnt", wr_cnt - wr_base, 0);
      do_req(1'b1, 32'h0000_0100, mk(32'hC000_0100), 3, "stall");
      check("stall_full", {511'b0, wb_full}, {511'b0, 1'b1});
      check("stall_wrcnt", wr_cnt - wr_base, 1);
      idle(12);
      check("fill_drained", wr_cnt - wr_base, 5);
      check("fill_empty", {511'b0, wb_empty}, {511'b0, 1'b1});

      // A pending read miss bypasses buffered writes.
      wr_base = wr_cnt;
      rd_base = rd_cnt;
      do_req(1'b1, 32'h0000_0040, mk(32'hCCCC_0040), 1, "bypC");
      do_req(1'b0, 32'h0000_0080, '0, 2 + MEM_LAT, "bypRd");
      check("byp_wrcnt", wr_cnt - wr_base, 0);
      check("byp_rdcnt", rd_cnt - rd_base, 1);
      check("byp_rdaddr", {480'b0, last_rd_addr}, {480'b0, 32'h0000_0080});
      idle(4);
      check("byp_drain", wr_cnt - wr_base, 1);

      // Mixed traffic over a few blocks; the scoreboard and drain monitor carry the checks.
      for (int i = 0; i < 40; i++) begin
         logic [PA_WIDTH-1:0]  a;
         logic [BLK_WIDTH-1:0] d;
         a = 32'h0000_8000 + (32'($urandom_range(0, 5)) << 6) + 32'($urandom_range(0, 63));
         for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
         do_req($urandom_range(0, 1) == 1, a, d, -1, "rnd");
      end
      idle(15);
      check("rnd_empty", {511'b0, wb_empty}, {511'b0, 1'b1});
      check("rnd_model", model_q.size(), 0);

      // Reset with two buffered entries and a read waiting on memory.
      do_req(1'b1, 32'h0000_1000, mk(32'hEEEE_1000), 1, "rstW0");
      do_req(1'b1, 32'h0000_1040, mk(32'hEEEE_1040), 1, "rstW1");
      cache_addr  = 32'h0000_3000;
      cache_wr_en = 1'b0;
      cache_rd_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rstRd_issue", {511'b0, mem_rd_en}, {511'b0, 1'b1});
      check("rstRd_pending", {511'b0, wb_empty}, '0);
      @(posedge clk);
      @(negedge clk);
      rst         = 1'b1;
      cache_rd_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      txn_q.delete();
      wr_base = wr_cnt;
      rd_base = rd_cnt;
      check("mid_rdy",    {511'b0, cache_rdy}, '0);
      check("mid_rd_blk", cache_rd_blk, '0);
      check("mid_mem_rd", {511'b0, mem_rd_en}, '0);
      check("mid_mem_wr", {511'b0, mem_wr_en}, '0);
      check("mid_addr",   {480'b0, mem_addr}, '0);
      check("mid_wr_blk", mem_wr_blk, '0);
      check("mid_empty",  {511'b0, wb_empty}, {511'b0, 1'b1});
      check("mid_full",   {511'b0, wb_full}, '0);
      idle(20);
      check("mid_no_wr", wr_cnt - wr_base, 0);
      check("mid_no_rd", rd_cnt - rd_base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_buffer.md
# wb_buffer

Write-back buffer between the cache's memory port and main memory. Absorbs dirty-block evictions from the cache into a small FIFO and drains them to memory when the memory port is idle. Services cache block reads by forwarding from the buffer on an address match, or by a memory read otherwise. Hides memory write latency from cache misses that evict dirty blocks.

## Interface
- PA_WIDTH, 32, physical address width.
- BLK_WIDTH, 512, cache block width in bits (64-byte block; offset = low 6 bits).
- DEPTH, 4, buffer entries (power of 2, ≥2).
- MEM_LAT, 1, cycles from `mem_rd_en` to valid `mem_rd_blk` (≥1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cache_addr  in  PA_WIDTH  block address from cache; offset bits ignored.
- cache_wr_en  in  1  eviction request; level, held until `cache_rdy`.
- cache_wr_blk  in  BLK_WIDTH  evicted block data.
- cache_rd_en  in  1  block fill request; level, held until `cache_rdy`.
- cache_rd_blk  out  BLK_WIDTH  fill data, valid while `cache_rdy`=1 for a read.
- cache_rdy  out  1  one-cycle completion pulse for the current request.
- mem_addr  out  PA_WIDTH  block-aligned memory address.
- mem_rd_en  out  1  memory read strobe, one cycle.
- mem_wr_en  out  1  memory write strobe, one cycle; memory commits at that edge.
- mem_wr_blk  out  BLK_WIDTH  block data to memory.
- mem_rd_blk  in  BLK_WIDTH  memory read data.
- wb_empty  out  1  no valid entries.
- wb_full  out  1  DEPTH valid entries.

## Operation
- Storage: circular FIFO of {aligned addr, block, valid}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- FSM states: IDLE, WR_ACC, RD_ISSUE, RD_WAIT, DRAIN, RESP.
- Requests are sampled only in IDLE. If both enables are high, the request is treated as a write and the read is ignored.
- IDLE, write, address matches a valid entry: coalesce. Overwrite that entry's data in place, keeping its FIFO position, then go to RESP.
- IDLE, write, no match, not full: push at tail, then RESP.
- IDLE, write, no match, full: go to DRAIN (head), then WR_ACC pushes the write, then RESP.
- IDLE, read, match: load the matching entry's data into `cache_rd_blk`, then RESP. No memory access.
- IDLE, read, no match: RD_ISSUE drives `mem_rd_en`=1 and `mem_addr` for one cycle. RD_WAIT counts MEM_LAT, then captures `mem_rd_blk` into `cache_rd_blk` and goes to RESP.
- Read misses bypass pending writes. This is safe because the addresses are disjoint (matches are forwarded).
- IDLE, no request, not empty: go to DRAIN. DRAIN drives `mem_wr_en`=1 with the head addr/data for one cycle, pops the head at its end, then returns to IDLE (or to WR_ACC on a full-stall).
- RESP: `cache_rdy`=1 for one cycle, then IDLE. The cache changes its request at that edge, so the same request is never accepted twice.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- `wb_empty` and `wb_full` are registered from the count.

## Timing
- Reset values: `cache_rdy`=0, `cache_rd_blk`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_blk`=0, `wb_empty`=1, `wb_full`=0, state IDLE, count 0, pointers 0, all valid bits cleared.
- Reset mid-operation discards all buffered entries and any outstanding read. No memory strobe is issued in the reset cycle or the cycle after it.
- Latencies (cycle 0 = IDLE cycle that samples the request):
  - Write accept or coalesce: `cache_rdy` in cycle 1.
  - Read hit: `cache_rdy` in cycle 1.
  - Read miss: `mem_rd_en` in cycle 1; `cache_rdy` in cycle 2+MEM_LAT.
  - Write when full: DRAIN in cycle 1, WR_ACC in cycle 2, `cache_rdy` in cycle 3.
- A request arriving while DRAIN is in progress is sampled in the following IDLE cycle. Worst-case added latency is 1 cycle.
- Simultaneous push and pop cannot occur; the count changes by at most 1 per cycle.
- Address compare uses bits [PA_WIDTH-1:6] only. `mem_addr` always has bits [5:0]=0.

## Test plan
- Reset, then read 0x00 with an empty buffer -> `mem_rd_en` in cycle 1 at `mem_addr`=0x00; `cache_rd_blk` = memory block 0; `cache_rdy` in cycle 3 (MEM_LAT=1).
- Write 0x20d5 with data A, then immediately read 0x20c0 -> write `cache_rdy` in cycle 1. The read hits the buffer and returns A with `cache_rdy` 1 cycle after sampling, with no `mem_rd_en`.
- Write 0x2000 with A, then write 0x2010 with B -> coalesced: count stays 1. After idle, exactly one `mem_wr_en` at `mem_addr`=0x2000 with B; then `wb_empty`=1.
- Write 0x000, 0x040, 0x080, 0x0C0 -> `wb_full`=1. A fifth write to 0x100 -> `mem_wr_en` for 0x000 first, `cache_rdy` 3 cycles after sampling, `wb_full` still 1. Later drains follow the order 0x040, 0x080, 0x0C0, 0x100.
- Write 0x40 with data C, then hold `cache_rd_en` for 0x80 -> the read miss is issued before any drain. After `cache_rdy`, with no request, 0x40 drains.
- Assert `rst` while 2 entries are pending and a read is in RD_WAIT -> next cycle all outputs are at reset values, `wb_empty`=1, and no `mem_wr_en` ever follows.
